// File: rtl/cve2_wb_arbiter_pkg.sv
// cve2_wb_arbiter_pkg: shared types, defaults and address-compare helpers for the writeback arbiter
// Exports: wb_entry_t (buffered load: addr, data, kill), FifoDepthDefault, WbDataWidth,
//          addr_eq/addr_nz (RV32E-aware register address compares).
package cve2_wb_arbiter_pkg;
  localparam int FifoDepthDefault = 2;
  // Widest register data the load buffer can hold; DataWidth must not exceed it.
  localparam int WbDataWidth = 32;
  typedef struct packed {
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
    logic                   kill;
  } wb_entry_t;
  // Under RV32E only x0..x15 exist, so bit 4 never distinguishes registers.
  function automatic logic addr_eq(input logic [4:0] a, input logic [4:0] b, input logic rv32e);
    return rv32e ? a[3:0] == b[3:0] : a == b;
  endfunction
  function automatic logic addr_nz(input logic [4:0] a, input logic rv32e);
    return rv32e ? |a[3:0] : |a;
  endfunction
endpackage

// File: rtl/cve2_wb_arbiter_if.sv
// cve2_wb_arbiter_if: execute/LSU writeback requests, register-file write port, hazards and buffer status
// slave: arbiter side (takes requests, drives write port/status); master: requester/test side.
interface cve2_wb_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 ex_valid_i;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 ex_ready_o;
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic [4:0]           raddr_a_i;
  logic [4:0]           raddr_b_i;
  logic                 hazard_a_o;
  logic                 hazard_b_o;
  logic                 fifo_full_o;
  logic                 fifo_empty_o;
  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i, lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
           raddr_a_i, raddr_b_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, hazard_a_o, hazard_b_o,
           fifo_full_o, fifo_empty_o
  );
  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i, lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
           raddr_a_i, raddr_b_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, hazard_a_o, hazard_b_o,
           fifo_full_o, fifo_empty_o
  );
endinterface

// File: rtl/cve2_wb_fifo.sv
// cve2_wb_fifo: load-writeback buffer with per-entry kill and live-entry read-address match
// In: clk, rst (async, active-high), push/push_entry, pop, kill_en/kill_addr, raddr_a/raddr_b.
// Out: head entry (kill reflects current kill state), full, empty, hit_a/hit_b.
module cve2_wb_fifo
  import cve2_wb_arbiter_pkg::*;
#(
  parameter int FifoDepth = FifoDepthDefault,
  parameter bit RV32E     = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  input  logic      kill_en,
  input  logic [4:0] kill_addr,
  input  logic [4:0] raddr_a,
  input  logic [4:0] raddr_b,
  output wb_entry_t head,
  output logic      full,
  output logic      empty,
  output logic      hit_a,
  output logic      hit_b
);
  localparam int PtrW = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);
  wb_entry_t            mem [FifoDepth];
  logic [FifoDepth-1:0] valid;
  logic [FifoDepth-1:0] kill_q;
  logic [PtrW-1:0]      rptr;
  logic [PtrW-1:0]      wptr;
  logic [CntW-1:0]      count;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(FifoDepth - 1) ? '0 : p + 1'b1;
  endfunction
  assign full  = count == CntW'(FifoDepth);
  assign empty = count == '0;
  always_comb begin
    head      = mem[rptr];
    head.kill = kill_q[rptr];
  end
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < FifoDepth; i++) begin
      hit_a = hit_a | (valid[i] && !kill_q[i] && addr_eq(mem[i].addr, raddr_a, RV32E));
      hit_b = hit_b | (valid[i] && !kill_q[i] && addr_eq(mem[i].addr, raddr_b, RV32E));
    end
  end
  // Order matters: a push into the slot freed by a same-cycle pop must win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      valid  <= '0;
      kill_q <= '0;
    end else begin
      for (int i = 0; i < FifoDepth; i++)
        if (kill_en && valid[i] && addr_eq(mem[i].addr, kill_addr, RV32E)) kill_q[i] <= 1'b1;
      if (pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= nxt(rptr);
      end
      if (push) begin
        valid[wptr]  <= 1'b1;
        kill_q[wptr] <= push_entry.kill;
        wptr         <= nxt(wptr);
      end
      count <= count + CntW'(push) - CntW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_entry;
  end
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/cve2_wb_arbiter.sv
// cve2_wb_arbiter: merges execute writes and load responses onto one register-file write port
// Ports: clk_i, rst_i (async, active-high); bus (cve2_wb_arbiter_if.slave) carrying the EX request,
// LSU response, register-file write port, decode read-address hazards and buffer status.
module cve2_wb_arbiter
  import cve2_wb_arbiter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter bit RV32E     = 1'b0,
  parameter int FifoDepth = FifoDepthDefault
) (
  input logic              clk_i,
  input logic              rst_i,
  cve2_wb_arbiter_if.slave bus
);
  wb_entry_t head;
  wb_entry_t push_entry;
  logic      full;
  logic      empty;
  logic      hit_a;
  logic      hit_b;
  logic      ex_ready;
  logic      ex_wr;
  logic      lsu_keep;
  logic      lsu_direct;
  logic      push;
  logic      pop;
  logic      pop_live;
  // A full buffer stalls EX so its head is guaranteed the port, which makes overflow impossible.
  assign ex_ready   = !full && !rst_i;
  assign ex_wr      = bus.ex_valid_i && ex_ready && addr_nz(bus.ex_waddr_i, RV32E);
  // The load is older than a concurrent EX write, so a matching EX write supersedes it.
  assign lsu_keep   = bus.lsu_valid_i && !rst_i && addr_nz(bus.lsu_waddr_i, RV32E) &&
                      !(ex_wr && addr_eq(bus.lsu_waddr_i, bus.ex_waddr_i, RV32E));
  assign pop        = !empty && !ex_wr && !rst_i;
  assign pop_live   = pop && !head.kill;
  // A load may bypass the buffer only when nothing older is queued, preserving write order.
  assign lsu_direct = lsu_keep && !ex_wr && empty;
  assign push       = lsu_keep && !lsu_direct;
  assign push_entry = '{addr: bus.lsu_waddr_i, data: WbDataWidth'(bus.lsu_wdata_i), kill: 1'b0};
  cve2_wb_fifo #(
    .FifoDepth(FifoDepth),
    .RV32E    (RV32E)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .kill_en   (ex_wr),
    .kill_addr (bus.ex_waddr_i),
    .raddr_a   (bus.raddr_a_i),
    .raddr_b   (bus.raddr_b_i),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .hit_a     (hit_a),
    .hit_b     (hit_b)
  );
  assign bus.ex_ready_o   = ex_ready;
  assign bus.rf_we_o      = ex_wr || pop_live || lsu_direct;
  assign bus.rf_waddr_o   = ex_wr ? bus.ex_waddr_i : pop_live ? head.addr :
                            lsu_direct ? bus.lsu_waddr_i : '0;
  assign bus.rf_wdata_o   = ex_wr ? bus.ex_wdata_i : pop_live ? DataWidth'(head.data) :
                            lsu_direct ? bus.lsu_wdata_i : '0;
  assign bus.hazard_a_o   = addr_nz(bus.raddr_a_i, RV32E) &&
                            (hit_a || (push && addr_eq(bus.raddr_a_i, bus.lsu_waddr_i, RV32E)));
  assign bus.hazard_b_o   = addr_nz(bus.raddr_b_i, RV32E) &&
                            (hit_b || (push && addr_eq(bus.raddr_b_i, bus.lsu_waddr_i, RV32E)));
  assign bus.fifo_full_o  = full;
  assign bus.fifo_empty_o = empty;
endmodule

// File: doc/cve2_wb_arbiter.md
CVE2_WB_ARBITER -- requirements
Module: cve2_wb_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter RV32E, default 0; when 1, address bit 4 is ignored in all address compares.
REQ-003 SHALL have parameter FifoDepth, default 2, number of load-writeback buffer entries (legal range 1..4).
REQ-004 SHALL have clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ex_valid_i, input, 1: execute stage presents a register write.
REQ-007 SHALL have ex_waddr_i, input, 5, and ex_wdata_i, input, DataWidth: execute write address and data.
REQ-008 SHALL have ex_ready_o, output, 1: execute write accepted this cycle.
REQ-009 SHALL have lsu_valid_i, input, 1: load response present (unstallable, always accepted).
REQ-010 SHALL have lsu_waddr_i, input, 5, and lsu_wdata_i, input, DataWidth: load destination and data.
REQ-011 SHALL have rf_we_o, input/output naming per codebase, output, 1, plus rf_waddr_o, output, 5, and rf_wdata_o, output, DataWidth: the register-file single write port.
REQ-012 SHALL have raddr_a_i and raddr_b_i, inputs, 5: decode read addresses; hazard_a_o and hazard_b_o, outputs, 1: read address matches a live buffered load.
REQ-013 SHALL have fifo_full_o, output, 1, and fifo_empty_o, output, 1: buffer status.

Function
REQ-014 SHALL drive the write port combinationally (zero latency); the register file captures it on the next rising edge.
REQ-015 SHALL prioritise per cycle: accepted EX write, then FIFO head, then direct LSU response.
REQ-016 SHALL assert ex_ready_o when the FIFO is not full; EX write reaches the port only when ex_valid_i and ex_ready_o are both high.
REQ-017 SHALL, when the FIFO is full, deassert ex_ready_o and drain the head that cycle.
REQ-018 SHALL push the LSU response into the FIFO whenever it does not win the port; simultaneous push and pop SHALL keep the count unchanged, including when full.
REQ-019 SHALL never overflow: a push with FIFO full is impossible because the head pops that cycle; an assertion SHALL flag violation.
REQ-020 SHALL treat an LSU response as older than a concurrent EX write; if their addresses match, the LSU data SHALL be discarded.
REQ-021 SHALL mark a FIFO entry killed when an accepted EX write matches its address; popping a killed entry SHALL keep rf_we_o low and free the slot.
REQ-022 SHALL never assert rf_we_o for address 0; writes to x0 SHALL NOT be pushed and SHALL NOT kill entries.
REQ-023 SHALL assert hazard_a_o/hazard_b_o when the read address is nonzero and matches any live (unkilled) entry, or a direct LSU response being pushed this cycle.
REQ-024 SHALL keep rf_waddr_o and rf_wdata_o at zero whenever rf_we_o is low.
REQ-025 SHALL implement the FIFO with read and write pointers that wrap modulo FifoDepth and a count of width clog2(FifoDepth+1).

Reset
REQ-026 SHALL, on rst_i assertion, immediately clear count, pointers, and valid/kill bits; fifo_empty_o=1, fifo_full_o=0, hazards=0.
REQ-027 SHALL discard buffered loads on reset mid-operation; no write issues until rst_i deasserts.
REQ-028 SHALL NOT reset the FIFO data storage.

Structure
REQ-029 SHALL place the FIFO entry struct (addr, data, kill) and FifoDepth default in the shared cve2 package.
REQ-030 SHALL instantiate one sub-module, cve2_wb_fifo, holding storage, pointers, count, and per-entry address compare.

Verification
REQ-031 SHALL check: EX x5=0x11 alone -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x11 same cycle, ex_ready_o=1.
REQ-032 SHALL check: EX x3 and LSU x7=0xAA same cycle -> port writes x3; next idle cycle writes x7=0xAA; hazard_a_o=1 for raddr_a_i=7 in between.
REQ-033 SHALL check: two LSU responses during continuous EX writes -> fifo_full_o=1, ex_ready_o=0, head drains next cycle in order.
REQ-034 SHALL check: LSU x9 buffered, then EX x9=0x55 accepted -> entry killed, pop gives rf_we_o=0, final x9=0x55.
REQ-035 SHALL check: LSU and EX both to x0 -> rf_we_o never asserted, FIFO stays empty.
REQ-036 SHALL check: rst_i asserted with FIFO full -> outputs cleared asynchronously, no write after release.
